// File: rtl/strobe_arb.sv
// strobe_arb: arbitrates NREQ requesters and issues GAP-spaced strobes to a clock-crossing channel.
// Default build uses round-robin arbitration.
// Define STROBE_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module strobe_arb #(
    parameter int IDW   = 2,
    parameter int WIDTH = 8,
    parameter int GAP   = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic [2**IDW-1:0]           req,
    input  logic [(2**IDW)*WIDTH-1:0]   req_data,
    output logic [2**IDW-1:0]           gnt,
    output logic                        strobe_out,
    output logic [IDW+WIDTH-1:0]        data_out,
    output logic                        busy,
    output logic [15:0]                 xfer_cnt
);
    localparam int NREQ = 2**IDW;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state;
    logic [7:0]     cnt;
    logic [IDW-1:0] win;
`ifndef STROBE_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] last_winner;
    logic [IDW-1:0] idx;
`endif

    // pick the winner; the last match in the loop is the highest-priority request
    always_comb begin
        win = '0;
`ifdef STROBE_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i]) win = IDW'(i);
`else
        idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last_winner + IDW'(i);
            if (req[idx]) win = idx;
        end
`endif
    end

    // IDLE/HOLD sequencer with registered grant, strobe, payload and transfer count
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= '0;
            strobe_out <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;
            xfer_cnt   <= '0;
`ifndef STROBE_ARB_FIXED_PRIO_EN
            last_winner <= IDW'(NREQ - 1);
`endif
        end else begin
            gnt        <= '0;
            strobe_out <= 1'b0;
            if (state == IDLE) begin
                if (|req) begin
                    gnt[win]   <= 1'b1;
                    strobe_out <= 1'b1;
                    data_out   <= {win, req_data[win*WIDTH +: WIDTH]};
                    xfer_cnt   <= xfer_cnt + 16'd1;
                    state      <= HOLD;
                    busy       <= 1'b1;
                    cnt        <= 8'(GAP - 1);
`ifndef STROBE_ARB_FIXED_PRIO_EN
                    last_winner <= win;
`endif
                end
            end else if (cnt == 8'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_strobe_arb.sv
// tb_strobe_arb: randomized scoreboard bench for strobe_arb against a transfer-level model.
module tb_strobe_arb;
    localparam int IDW   = 2;
    localparam int WIDTH = 8;
    localparam int GAP   = 4;
    localparam int NREQ  = 2**IDW;
    localparam int DW    = IDW + WIDTH;

    logic                  clk_in = 1'b0;
    logic                  rst_n  = 1'b0;
    logic [NREQ-1:0]       req    = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       gnt;
    logic                  strobe_out;
    logic [DW-1:0]         data_out;
    logic                  busy;
    logic [15:0]           xfer_cnt;

    strobe_arb #(.IDW(IDW), .WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .strobe_out(strobe_out), .data_out(data_out),
        .busy(busy), .xfer_cnt(xfer_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
        logic [15:0]     cnt;
    } xfer_t;

    typedef struct {
        bit            stb;
        bit            busy;
        logic [DW-1:0] data;
        logic [15:0]   cnt;
    } stat_t;

    xfer_t tq[$];
    stat_t sq[$];

    int n_chk = 0;
    int n_err = 0;

    bit               pend[NREQ];
    logic [WIDTH-1:0] pdata[NREQ];
    int               ptr = 0;
    int               left = 0;
    logic [15:0]      m_cnt = '0;
    logic [DW-1:0]    m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of inputs and predict what the DUT shows after the coming edge
    task automatic step(input bit rst, input bit all_req);
        int    w;
        xfer_t x;
        @(negedge clk_in);
        #1;
        rst_n = !rst;
        for (int i = 0; i < NREQ; i++) begin
            if (all_req) begin
                if (!pend[i]) pdata[i] = WIDTH'($urandom);
                pend[i] = 1'b1;
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i]  = 1'b1;
                pdata[i] = WIDTH'($urandom);
            end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                pend[i] = 1'b0;
            end
            req[i] = pend[i];
            req_data[i*WIDTH +: WIDTH] = pend[i] ? pdata[i] : WIDTH'($urandom);
        end
        w = -1;
        if (rst) begin
            ptr = 0; left = 0; m_cnt = '0; m_data = '0;
        end else if (left == 0 && req != '0) begin
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
            m_cnt  = m_cnt + 16'd1;
            m_data = {IDW'(w), pdata[w]};
            left   = GAP - 1;
`ifdef STROBE_ARB_FIXED_PRIO_EN
            ptr = 0;
`else
            ptr = (w + 1) % NREQ;
`endif
            x.gnt    = '0;
            x.gnt[w] = 1'b1;
            x.data   = m_data;
            x.cnt    = m_cnt;
            tq.push_back(x);
            pend[w] = 1'b0;
        end else if (left > 0) begin
            left--;
        end
        sq.push_back('{stb: (w >= 0), busy: (left > 0), data: m_data, cnt: m_cnt});
    endtask

    // monitor: per-cycle status check, transfer check whenever a strobe appears
    initial begin
        stat_t s;
        xfer_t x;
        forever begin
            @(negedge clk_in);
            if (sq.size() != 0) begin
                s = sq.pop_front();
                chk("strobe", 32'(strobe_out), 32'(s.stb));
                chk("busy", 32'(busy), 32'(s.busy));
                chk("xfer_cnt", 32'(xfer_cnt), 32'(s.cnt));
                chk("data_out", 32'(data_out), 32'(s.data));
                if (strobe_out) begin
                    if (tq.size() == 0) begin
                        chk("unexpected_strobe", 32'(gnt), 32'(0));
                    end else begin
                        x = tq.pop_front();
                        chk("gnt", 32'(gnt), 32'(x.gnt));
                        chk("xfer_data", 32'(data_out), 32'(x.data));
                        chk("xfer_cnt_at_strobe", 32'(xfer_cnt), 32'(x.cnt));
                    end
                end else begin
                    chk("gnt_without_strobe", 32'(gnt), 32'(0));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end
        repeat (3) step(1'b1, 1'b1);
        repeat (24) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        repeat (3000) step($urandom_range(0, 199) == 0, 1'b0);
        repeat (2) @(negedge clk_in);
        chk("queues_drained", 32'(tq.size() + sq.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/strobe_arb.md
STROBE_ARB -- requirements
Module: strobe_arb

Interface
REQ-001 SHALL have parameter IDW, default 2, meaning requester index width; NREQ = 2**IDW requesters.
REQ-002 SHALL have parameter WIDTH, default 8, meaning payload width per requester.
REQ-003 SHALL have parameter GAP, default 4, meaning minimum clk_in cycles between strobes; legal range 2..255.
REQ-004 SHALL have port clk_in  input  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req  input  NREQ  per-requester level request.
REQ-007 SHALL have port req_data  input  NREQ*WIDTH  payloads; requester i owns bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gnt  output  NREQ  one-hot, one-cycle grant pulse; the request is consumed.
REQ-009 SHALL have port strobe_out  output  1  one-cycle pulse driving the strobe input of the clock-crossing channel.
REQ-010 SHALL have port data_out  output  IDW+WIDTH  {winner index, winner payload} for the crossing channel.
REQ-011 SHALL have port busy  output  1  high while in HOLD.
REQ-012 SHALL have port xfer_cnt  output  16  count of issued strobes.

Function
REQ-013 SHALL implement FSM states IDLE and HOLD, plus an 8-bit holdoff counter.
REQ-014 In IDLE with any req bit high at edge k, the block SHALL select a winner and register the following, visible in cycle k+1: gnt (winner bit only), strobe_out=1, data_out, xfer_cnt+1, state=HOLD, counter=GAP-1.
REQ-015 In IDLE with req==0, the block SHALL stay in IDLE and keep gnt=0 and strobe_out=0.
REQ-016 gnt and strobe_out SHALL be high for exactly one cycle per transfer and SHALL always coincide.
REQ-017 In HOLD, the counter SHALL decrement each cycle; HOLD SHALL exit to IDLE on the cycle the counter would reach 0.
REQ-018 req SHALL be ignored in HOLD, so consecutive strobes are spaced exactly GAP cycles under continuous request.
REQ-019 data_out SHALL hold its value from one strobe until the next strobe.
REQ-020 Arbitration SHALL be round-robin: the search starts at last_winner+1 and wraps from NREQ-1 to 0; last_winner updates on every grant.
REQ-021 A requester SHALL hold req and its req_data stable until gnt; it may drop req before grant with no side effect.
REQ-022 A requester that holds req through a gnt cycle SHALL be treated as a new request in the next IDLE evaluation.
REQ-023 xfer_cnt SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-024 busy SHALL equal (state==HOLD), registered.

Reset
REQ-025 When rst_n is low at a rising edge, the block SHALL set, in the next cycle: state=IDLE, counter=0, gnt=0, strobe_out=0, data_out=0, busy=0, xfer_cnt=0, last_winner=NREQ-1.
REQ-026 A reset asserted mid-HOLD or in a grant cycle SHALL abort the transfer; no strobe_out SHALL be issued while rst_n is low.
REQ-027 On the first edge with rst_n high, arbitration SHALL proceed normally, with requester 0 first in search order.

Configuration
REQ-028 SHALL support macro STROBE_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed-priority with the lowest index winning and last_winner unused; when undefined, arbitration is round-robin per REQ-020.

Verification
REQ-029 Reset: rst_n low 3 cycles with req=4'b1111 -> no gnt/strobe_out during reset; all outputs 0; first grant after release to req0.
REQ-030 Single transfer (GAP=4): req[1]=1 with payload 0xA5 sampled at edge 10 -> cycle 11 gnt=4'b0010, strobe_out=1, data_out=10'h1A5, busy=1 cycles 11-13, IDLE by cycle 14.
REQ-031 Round-robin: req=4'b1111 held -> grants 0,1,2,3,0 at 4-cycle spacing; xfer_cnt 1..5; data_out index matches each grant.
REQ-032 HOLD masking: req[2] high only in cycles 12-13 during HOLD -> no gnt[2]; strobe count unchanged.
REQ-033 Mid-HOLD reset: rst_n low at cycle 12 -> cycle 13 busy=0 and xfer_cnt=0; req0 held -> grant 0 one cycle after release.
REQ-034 STROBE_ARB_FIXED_PRIO_EN defined, req=4'b1001 held -> every grant to req0; xfer_cnt increments each GAP cycles.
